// File: rtl/float_pkg.sv
// Shared opcode, rounding/precision and issue-queue FSM definitions for float_alu and its queue.
package float_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MIN = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;

    localparam logic ROUND_NEAREST_EVEN = 1'b0;
    localparam logic ROUND_ZERO         = 1'b1;
    localparam logic MODE_HALF          = 1'b0;
    localparam logic MODE_SINGLE        = 1'b1;

    localparam int DATA_W_DEFAULT = 32;

    // Queue entry: {op_a, op_b, op_code, round_mode, mode_fp}
    function automatic int opq_entry_w(input int data_w);
        return 2 * data_w + 5;
    endfunction

    localparam int OPQ_ENTRY_W = 2 * DATA_W_DEFAULT + 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } opq_state_t;
endpackage

// File: rtl/float_op_queue_if.sv
// Producer-side and ALU-side signals of float_op_queue; slave = queue, master = producer/ALU side.
interface float_op_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_op_a;
    logic [DATA_W-1:0]       in_op_b;
    logic [2:0]              in_op_code;
    logic                    in_round_mode;
    logic                    in_mode_fp;
    logic                    flush;
    logic                    alu_start;
    logic [DATA_W-1:0]       alu_op_a;
    logic [DATA_W-1:0]       alu_op_b;
    logic [2:0]              alu_op_code;
    logic                    alu_round_mode;
    logic                    alu_mode_fp;
    logic                    alu_ready_out;
    logic                    alu_valid_out;
    logic [$clog2(DEPTH):0]  count;
    logic                    busy;

    modport master (
        output in_valid, in_op_a, in_op_b, in_op_code, in_round_mode, in_mode_fp, flush,
               alu_ready_out, alu_valid_out,
        input  in_ready, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_round_mode,
               alu_mode_fp, count, busy
    );

    modport slave (
        input  in_valid, in_op_a, in_op_b, in_op_code, in_round_mode, in_mode_fp, flush,
               alu_ready_out, alu_valid_out,
        output in_ready, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_round_mode,
               alu_mode_fp, count, busy
    );
endinterface

// File: rtl/float_op_queue_fifo.sv
// fifo_sync: synchronous FIFO with flush; head word is visible combinationally for same-edge pop.
module fifo_sync #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Flush wins over both push and pop on the same edge
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/float_op_queue.sv
// Issue queue in front of float_alu: buffers ops and issues them one at a time via start/valid_out.
// Optional same-edge bypass into an empty idle queue: define FLOAT_OPQ_BYPASS_EN.
module float_op_queue
    import float_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    float_op_queue_if.slave   bus
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = opq_entry_w(DATA_W);

    opq_state_t          r_state;
    opq_state_t          w_state_next;
    logic [ENTRY_W-1:0]  w_push_data;
    logic [ENTRY_W-1:0]  w_head;
    logic [ENTRY_W-1:0]  w_issue_data;
    logic [CW-1:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_bypass;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [2:0]          r_op_code;
    logic                r_round_mode;
    logic                r_mode_fp;

    assign w_push_data = {bus.in_op_a, bus.in_op_b, bus.in_op_code, bus.in_round_mode, bus.in_mode_fp};
    assign w_accept    = bus.in_valid & ~w_full;

`ifdef FLOAT_OPQ_BYPASS_EN
    assign w_bypass = w_accept & w_empty & (r_state == IDLE) & bus.alu_ready_out & ~bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_issue      = (r_state == IDLE) & bus.alu_ready_out & ~bus.flush & (~w_empty | w_bypass);
    assign w_pop        = w_issue & ~w_bypass;
    assign w_push       = w_accept & ~w_bypass;
    assign w_issue_data = w_bypass ? w_push_data : w_head;

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_issue) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (bus.alu_valid_out) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operands only move on the IDLE->ISSUE edge and stay frozen through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_code    <= '0;
            r_round_mode <= 1'b0;
            r_mode_fp    <= 1'b0;
        end else if (w_issue) begin
            {r_op_a, r_op_b, r_op_code, r_round_mode, r_mode_fp} <= w_issue_data;
        end
    end

    always_comb begin
        bus.alu_start      = (r_state == ISSUE);
        bus.busy           = (r_state != IDLE) | ~w_empty;
        bus.in_ready       = ~w_full;
        bus.count          = w_count;
        bus.alu_op_a       = r_op_a;
        bus.alu_op_b       = r_op_b;
        bus.alu_op_code    = r_op_code;
        bus.alu_round_mode = r_round_mode;
        bus.alu_mode_fp    = r_mode_fp;
    end
endmodule

// File: tb/tb_float_op_queue.sv
// Self-checking bench for float_op_queue: vector table, hand-written reset/latency sequences,
// and randomized traffic against a queue-based reference model (works with or without FLOAT_OPQ_BYPASS_EN).
module tb_float_op_queue;
    import float_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int EW     = 2 * DATA_W + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    float_op_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    float_op_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        fl;
        logic        rdy;
        logic        vo;
        logic        e_start;
        int          e_cnt;
        logic        e_rdy;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_op_a       = '0;
        bus.in_op_b       = '0;
        bus.in_op_code    = '0;
        bus.in_round_mode = 1'b0;
        bus.in_mode_fp    = 1'b0;
        bus.flush         = 1'b0;
        bus.alu_ready_out = 1'b0;
        bus.alu_valid_out = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic rm, input logic rdy);
        bus.in_valid      = 1'b1;
        bus.in_op_a       = a;
        bus.in_op_b       = b;
        bus.in_op_code    = op;
        bus.in_round_mode = rm;
        bus.in_mode_fp    = MODE_HALF;
        bus.alu_ready_out = rdy;
        @(posedge clk); #1;
    endtask

    // Reference model state: pending ops in order, plus the in-flight op's phase
    logic [EW-1:0] mq [$];
    logic [EW-1:0] m_ops;
    bit            m_start;
    bit            m_wait;

    initial begin
        vecs[0]  = '{1'b1, 32'h4D30, 32'h4080, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[1]  = '{1'b1, 32'h4B00, 32'hCA20, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[2]  = '{1'b1, 32'h4810, 32'h4820, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[3]  = '{1'b1, 32'h4540, 32'h4CA0, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, 32'h1111, 32'h2222, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b1, 32'h4D30, 32'h4080, 1'b1};
        vecs[6]  = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h4D30, 32'h4080, 1'b1};
        vecs[7]  = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b1, 32'h4D30, 32'h4080, 1'b1};
        vecs[8]  = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1, 32'h4B00, 32'hCA20, 1'b1};
        vecs[9]  = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h4B00, 32'hCA20, 1'b1};
        vecs[10] = '{1'b1, 32'h3333, 32'h4444, OP_MUL, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h4B00, 32'hCA20, 1'b1};
        vecs[11] = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h4B00, 32'hCA20, 1'b0};
        vecs[12] = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h4B00, 32'hCA20, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 32'h4B00, 32'hCA20, 1'b0};

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_start", EW'(bus.alu_start), EW'(0));
        chk("reset_count", EW'(bus.count), EW'(0));
        chk("reset_in_ready", EW'(bus.in_ready), EW'(1));
        chk("reset_busy", EW'(bus.busy), EW'(0));
        chk("reset_op_a", EW'(bus.alu_op_a), EW'(0));
        rst = 1'b0;

        // Fill while stalled, overflow attempt, ordered issue, flush during WAIT, spurious valid_out
        for (int i = 0; i < 14; i++) begin
            bus.in_valid      = vecs[i].v;
            bus.in_op_a       = vecs[i].a;
            bus.in_op_b       = vecs[i].b;
            bus.in_op_code    = vecs[i].op;
            bus.in_round_mode = ROUND_NEAREST_EVEN;
            bus.in_mode_fp    = MODE_HALF;
            bus.flush         = vecs[i].fl;
            bus.alu_ready_out = vecs[i].rdy;
            bus.alu_valid_out = vecs[i].vo;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_start", i), EW'(bus.alu_start), EW'(vecs[i].e_start));
            chk($sformatf("vec%0d_count", i), EW'(bus.count), EW'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i), EW'(bus.in_ready), EW'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_op_a", i), EW'(bus.alu_op_a), EW'(vecs[i].e_a));
            chk($sformatf("vec%0d_op_b", i), EW'(bus.alu_op_b), EW'(vecs[i].e_b));
            chk($sformatf("vec%0d_busy", i), EW'(bus.busy), EW'(vecs[i].e_busy));
            $display("vec %0d: start=%0d count=%0d in_ready=%0d op_a=%h busy=%0d",
                     i, bus.alu_start, bus.count, bus.in_ready, bus.alu_op_a, bus.busy);
        end

        // Async reset while in WAIT with three entries queued
        drive_idle();
        push(32'hA001, 32'hB001, OP_ADD, 1'b0, 1'b1);
        push(32'hA002, 32'hB002, OP_ADD, 1'b0, 1'b1);
        push(32'hA003, 32'hB003, OP_ADD, 1'b0, 1'b1);
        push(32'hA004, 32'hB004, OP_ADD, 1'b0, 1'b1);
        chk("prerst_count", EW'(bus.count), EW'(3));
        chk("prerst_start", EW'(bus.alu_start), EW'(0));
        chk("prerst_op_a", EW'(bus.alu_op_a), EW'(32'hA001));
        drive_idle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", EW'(bus.count), EW'(0));
        chk("midrst_start", EW'(bus.alu_start), EW'(0));
        chk("midrst_op_a", EW'(bus.alu_op_a), EW'(0));
        chk("midrst_busy", EW'(bus.busy), EW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-WAIT: count=%0d op_a=%h", bus.count, bus.alu_op_a);

        // Push into empty idle queue with ALU ready: issue latency depends on bypass build
        push(32'h7BFF, 32'h7BFF, OP_MUL, ROUND_ZERO, 1'b1);
        bus.in_valid = 1'b0;
`ifdef FLOAT_OPQ_BYPASS_EN
        chk("lat_e0_start", EW'(bus.alu_start), EW'(1));
        chk("lat_e0_count", EW'(bus.count), EW'(0));
        chk("lat_e0_op_a", EW'(bus.alu_op_a), EW'(32'h7BFF));
        @(posedge clk); #1;
        chk("lat_e1_start", EW'(bus.alu_start), EW'(0));
        chk("lat_e1_round", EW'(bus.alu_round_mode), EW'(1));
`else
        chk("lat_e0_start", EW'(bus.alu_start), EW'(0));
        chk("lat_e0_count", EW'(bus.count), EW'(1));
        chk("lat_e0_op_a", EW'(bus.alu_op_a), EW'(0));
        @(posedge clk); #1;
        chk("lat_e1_start", EW'(bus.alu_start), EW'(1));
        chk("lat_e1_count", EW'(bus.count), EW'(0));
        chk("lat_e1_op_a", EW'(bus.alu_op_a), EW'(32'h7BFF));
        chk("lat_e1_round", EW'(bus.alu_round_mode), EW'(1));
`endif
        @(posedge clk); #1;
        bus.alu_valid_out = 1'b1;
        @(posedge clk); #1;
        bus.alu_valid_out = 1'b0;
        chk("lat_done_busy", EW'(bus.busy), EW'(0));
        chk("lat_done_start", EW'(bus.alu_start), EW'(0));
        $display("latency op done: op_b=%h busy=%0d", bus.alu_op_b, bus.busy);

        // Randomized traffic against the reference model
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_ops   = '0;
        m_start = 1'b0;
        m_wait  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic          v, fl, rd, vo;
            logic [EW-1:0] e;
            int            qn;
            bit            acc, byp;
            v  = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 9) < 6);
            vo = ($urandom_range(0, 9) < 3);
            e  = {$urandom(), $urandom(), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            bus.in_valid = v;
            {bus.in_op_a, bus.in_op_b, bus.in_op_code, bus.in_round_mode, bus.in_mode_fp} = e;
            bus.flush         = fl;
            bus.alu_ready_out = rd;
            bus.alu_valid_out = vo;

            qn  = mq.size();
            acc = v && (qn < DEPTH);
            byp = 1'b0;
            if (m_start) begin
                m_start = 1'b0;
                m_wait  = 1'b1;
            end else if (m_wait) begin
                if (vo) m_wait = 1'b0;
            end else if (!fl && rd) begin
                if (qn > 0) begin
                    m_ops   = mq.pop_front();
                    m_start = 1'b1;
                end
`ifdef FLOAT_OPQ_BYPASS_EN
                else if (acc) begin
                    m_ops   = e;
                    m_start = 1'b1;
                    byp     = 1'b1;
                end
`endif
            end
            if (fl) mq.delete();
            else if (acc && !byp) mq.push_back(e);

            @(posedge clk); #1;
            chk("rnd_start", EW'(bus.alu_start), EW'(m_start));
            chk("rnd_count", EW'(bus.count), EW'(mq.size()));
            chk("rnd_in_ready", EW'(bus.in_ready), EW'(mq.size() < DEPTH));
            chk("rnd_busy", EW'(bus.busy), EW'(m_start || m_wait || (mq.size() != 0)));
            chk("rnd_ops", {bus.alu_op_a, bus.alu_op_b, bus.alu_op_code, bus.alu_round_mode, bus.alu_mode_fp}, m_ops);
            if (bus.alu_start)
                $display("issue cycle %0d: a=%h b=%h op=%0d rm=%0d fp=%0d", c,
                         bus.alu_op_a, bus.alu_op_b, bus.alu_op_code, bus.alu_round_mode, bus.alu_mode_fp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
